// File: rtl/sim_mon_pkg.sv
// Shared types for the simulation error monitor.
// State and cause encodings live here.
package sim_mon_pkg;

  localparam int ERR_CODE_W = 2;

  typedef enum logic [1:0] {
    S_RUN,
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [ERR_CODE_W-1:0] {
    ERR_NONE = 2'd0,
    ERR_SRC  = 2'd1,
    ERR_WDOG = 2'd2,
    ERR_CYC  = 2'd3
  } err_code_e;

endpackage

// File: rtl/sim_err_monitor_if.sv
// Monitor bus: error sources, commit/halt in,
// sticky status and counters out.
interface sim_err_monitor_if
  import sim_mon_pkg::*;
#(
  parameter int unsigned NSRC = 8
);
  logic [NSRC-1:0]       err_src;
  logic                  commit;
  logic                  halt;
  logic                  err;
  logic [ERR_CODE_W-1:0] err_code;
  logic [NSRC-1:0]       err_vec;
  logic                  done;
  logic [31:0]           cycle_cnt;
  logic [31:0]           instr_cnt;

  modport master (
    output err_src, commit, halt,
    input  err, err_code, err_vec,
    input  done, cycle_cnt, instr_cnt
  );

  modport slave (
    input  err_src, commit, halt,
    output err, err_code, err_vec,
    output done, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/sim_watchdog.sv
// Counts consecutive no-commit RUN cycles and
// flags the cycle that would reach the limit.
module sim_watchdog #(
  parameter int unsigned WDOG_LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic commit_i,
  output logic timeout
);
  localparam logic [31:0] LIM_M1 =
    32'(WDOG_LIMIT - 1);

  logic [31:0] idle_q, idle_d;

  // idle count: cleared by commit, frozen outside RUN
  always_comb begin
    idle_d = idle_q;
    if (run_i) begin
      idle_d = commit_i ? '0 : idle_q + 32'd1;
    end
  end

  // idle counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end

  assign timeout = run_i && !commit_i &&
                   (idle_q == LIM_M1);
endmodule

// File: rtl/sim_err_monitor.sv
// Run monitor: counts cycles/commits, latches the
// first error cause or clean halt, then freezes.
module sim_err_monitor
  import sim_mon_pkg::*;
#(
  parameter int unsigned NSRC       = 8,
  parameter int unsigned WDOG_LIMIT = 1000,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input logic              clk,
  input logic              rst_n,
  sim_err_monitor_if.slave bus
);
  localparam logic [31:0] CYC_M1 =
    32'(MAX_CYCLES - 1);

  if (MAX_CYCLES == 0 || WDOG_LIMIT == 0)
  begin : g_param_chk
    $error("MAX_CYCLES and WDOG_LIMIT must be >= 1");
  end

  state_e                state_q, state_d;
  logic                  err_q, err_d;
  logic [ERR_CODE_W-1:0] code_q, code_d;
  logic [NSRC-1:0]       vec_q, vec_d;
  logic                  done_q, done_d;
  logic [31:0]           cyc_q, cyc_d;
  logic [31:0]           ins_q, ins_d;

  logic run;
  logic src_hit;
  logic wdog_hit;
  logic cyc_hit;

  assign run     = (state_q == S_RUN);
  assign src_hit = |bus.err_src;
  assign cyc_hit = (cyc_q == CYC_M1);

  sim_watchdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (run),
    .commit_i (bus.commit),
    .timeout  (wdog_hit)
  );

  // next state: count in RUN, first cause wins
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    code_d  = code_q;
    vec_d   = vec_q;
    done_d  = done_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    if (run) begin
      cyc_d = cyc_q + 32'd1;
      if (bus.commit) ins_d = ins_q + 32'd1;
      if (src_hit) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        code_d  = ERR_SRC;
        vec_d   = bus.err_src;
      end else if (wdog_hit) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        code_d  = ERR_WDOG;
      end else if (cyc_hit) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        code_d  = ERR_CYC;
      end else if (bus.halt) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      vec_q   <= '0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      code_q  <= code_d;
      vec_q   <= vec_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
  assign bus.err_vec   = vec_q;
  assign bus.done      = done_q;
  assign bus.cycle_cnt = cyc_q;
  assign bus.instr_cnt = ins_q;
endmodule

// File: tb/tb_sim_err_monitor.sv
// Directed and random checks of sim_err_monitor
// against a cycle-level reference model.
module tb_sim_err_monitor;
  localparam int unsigned WDOG = 5;
  localparam int unsigned MAXC = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sim_err_monitor_if #(.NSRC(8)) bus ();

  sim_err_monitor #(
    .NSRC       (8),
    .WDOG_LIMIT (WDOG),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  bit          m_live;
  bit          m_err;
  bit          m_done;
  logic [1:0]  m_code;
  logic [7:0]  m_vec;
  int unsigned m_cyc;
  int unsigned m_ins;
  int unsigned m_idle;

  function automatic void model_reset();
    m_live = 1; m_err = 0; m_done = 0;
    m_code = 2'd0; m_vec = 8'h00;
    m_cyc = 0; m_ins = 0; m_idle = 0;
  endfunction

  function automatic void model_edge(
    input logic [7:0] s, input logic c,
    input logic h);
    bit src, wd, lim;
    if (!m_live) return;
    src = (s != 8'h00);
    wd  = !c && (m_idle + 1 == WDOG);
    lim = (m_cyc + 1 == MAXC);
    m_cyc = m_cyc + 1;
    if (c) m_ins = m_ins + 1;
    m_idle = c ? 0 : m_idle + 1;
    if (src) begin
      m_err = 1; m_code = 2'd1; m_vec = s; m_live = 0;
    end else if (wd) begin
      m_err = 1; m_code = 2'd2; m_live = 0;
    end else if (lim) begin
      m_err = 1; m_code = 2'd3; m_live = 0;
    end else if (h) begin
      m_done = 1; m_live = 0;
    end
  endfunction

  task automatic chk(input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
    chk({tag, ".code"}, 32'(bus.err_code),
        32'(m_code));
    chk({tag, ".vec"}, 32'(bus.err_vec), 32'(m_vec));
    chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
    chk({tag, ".cyc"}, bus.cycle_cnt, m_cyc);
    chk({tag, ".ins"}, bus.instr_cnt, m_ins);
  endtask

  task automatic step(input logic [7:0] s,
    input logic c, input logic h,
    input string tag);
    bus.err_src = s;
    bus.commit  = c;
    bus.halt    = h;
    @(posedge clk);
    model_edge(s, c, h);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.err_src = 8'h00;
    bus.commit  = 1'b0;
    bus.halt    = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("reset0");
    @(negedge clk);
    rst_n = 1'b1;

    // source error at RUN cycle 10, sticky
    for (int i = 0; i < 10; i++)
      step(8'h00, 1'b1, 1'b0, "src_pre");
    step(8'h04, 1'b1, 1'b0, "src_hit");
    chk("src_err", 32'(bus.err), 32'd1);
    chk("src_code", 32'(bus.err_code), 32'd1);
    chk("src_vec", 32'(bus.err_vec), 32'h04);
    for (int i = 0; i < 3; i++)
      step(8'hF0, 1'b1, 1'b1, "src_sticky");
    chk("src_cyc_frozen", bus.cycle_cnt, 32'd11);

    // watchdog fires on 5th idle cycle
    do_reset("rst_wd");
    for (int i = 0; i < 4; i++)
      step(8'h00, 1'b0, 1'b0, "wd_idle");
    chk("wd_not_yet", 32'(bus.err), 32'd0);
    step(8'h00, 1'b0, 1'b0, "wd_fire");
    chk("wd_code", 32'(bus.err_code), 32'd2);

    // commit in 4th idle... would-be timeout slot
    do_reset("rst_wd2");
    for (int i = 0; i < 4; i++)
      step(8'h00, 1'b0, 1'b0, "wd2_idle");
    step(8'h00, 1'b1, 1'b0, "wd2_save");
    for (int i = 0; i < 4; i++)
      step(8'h00, 1'b0, 1'b0, "wd2_idle2");
    chk("wd2_no_err", 32'(bus.err), 32'd0);

    // cycle limit with commit every cycle
    do_reset("rst_cyc");
    for (int i = 0; i < 19; i++)
      step(8'h00, 1'b1, 1'b0, "cyc_run");
    chk("cyc_not_yet", 32'(bus.err), 32'd0);
    step(8'h00, 1'b1, 1'b0, "cyc_fire");
    chk("cyc_code", 32'(bus.err_code), 32'd3);
    chk("cyc_cnt", bus.cycle_cnt, 32'd20);
    chk("cyc_ins", bus.instr_cnt, 32'd20);
    step(8'h00, 1'b1, 1'b0, "cyc_frozen");

    // watchdog and cycle limit same cycle
    do_reset("rst_pri");
    for (int i = 0; i < 15; i++)
      step(8'h00, 1'b1, 1'b0, "pri_run");
    for (int i = 0; i < 5; i++)
      step(8'h00, 1'b0, 1'b0, "pri_idle");
    chk("pri_code", 32'(bus.err_code), 32'd2);

    // halt with coincident source error
    do_reset("rst_hs");
    for (int i = 0; i < 3; i++)
      step(8'h00, 1'b1, 1'b0, "hs_run");
    step(8'h81, 1'b1, 1'b1, "hs_hit");
    chk("hs_code", 32'(bus.err_code), 32'd1);
    chk("hs_vec", 32'(bus.err_vec), 32'h81);
    chk("hs_done", 32'(bus.done), 32'd0);

    // clean halt after 7 commits
    do_reset("rst_h");
    for (int i = 0; i < 7; i++)
      step(8'h00, 1'b1, 1'b0, "h_run");
    step(8'h00, 1'b0, 1'b1, "h_halt");
    chk("h_done", 32'(bus.done), 32'd1);
    chk("h_ins", bus.instr_cnt, 32'd7);
    for (int i = 0; i < 3; i++)
      step(8'hFF, 1'b1, 1'b0, "h_ign");
    chk("h_no_err", 32'(bus.err), 32'd0);

    // async reset while in ERROR
    do_reset("rst_ar");
    step(8'h00, 1'b1, 1'b0, "ar_run");
    step(8'h10, 1'b1, 1'b0, "ar_err");
    step(8'h00, 1'b1, 1'b0, "ar_hold");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("ar_async");
    chk("ar_err0", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step(8'h00, 1'b1, 1'b0, "ar_resume");
    chk("ar_cyc", bus.cycle_cnt, 32'd3);

    // random runs against the model
    for (int r = 0; r < 20; r++) begin
      do_reset("rnd_rst");
      for (int i = 0; i < 25; i++) begin
        logic [7:0] s;
        logic c, h;
        s = ($urandom_range(0, 15) == 0) ?
            8'($urandom) : 8'h00;
        c = ($urandom_range(0, 3) != 0);
        h = ($urandom_range(0, 19) == 0);
        step(s, c, h, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/sim_err_monitor.md
SIM_ERR_MONITOR -- requirements
Module: sim_err_monitor

Interface
REQ-001 Parameter NSRC, 8, number of per-stage error sources.
REQ-002 Parameter WDOG_LIMIT, 1000, consecutive no-commit cycles before a watchdog error.
REQ-003 Parameter MAX_CYCLES, 100000, RUN cycles before a cycle-limit error.
REQ-004 Port clk  input  1  system clock; all state on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port err_src  input  NSRC  per-stage error pulses, sampled each cycle.
REQ-007 Port commit  input  1  one instruction retired this cycle.
REQ-008 Port halt  input  1  program-complete pulse.
REQ-009 Port err  output  1  sticky error flag to the clock/reset generator.
REQ-010 Port err_code  output  2  cause: 0 none, 1 source, 2 watchdog, 3 cycle limit.
REQ-011 Port err_vec  output  NSRC  err_src bits captured on the error cycle.
REQ-012 Port done  output  1  program halted cleanly.
REQ-013 Port cycle_cnt  output  32  RUN cycles elapsed.
REQ-014 Port instr_cnt  output  32  commits counted.

Function
REQ-015 FSM states: RUN, DONE, ERROR; all outputs registered.
REQ-016 RUN: cycle_cnt +1 per cycle; instr_cnt +1 per cycle with commit=1.
REQ-017 Idle counter: cleared on commit=1, else +1; only counts in RUN.
REQ-018 RUN->ERROR code 1 when any err_src bit = 1; err_vec <= err_src same edge.
REQ-019 RUN->ERROR code 2 when idle counter == WDOG_LIMIT-1 and commit=0.
REQ-020 RUN->ERROR code 3 when cycle_cnt == MAX_CYCLES-1.
REQ-021 RUN->DONE when halt=1 and no error condition this cycle; done=1 next cycle.
REQ-022 Priority same cycle: code 1 > code 2 > code 3 > halt.
REQ-023 Multiple err_src bits same cycle: all captured in err_vec; single code 1.
REQ-024 commit=1 in the would-be timeout cycle clears the idle counter; no watchdog error.
REQ-025 err, err_code, err_vec rise the cycle after the causing event.
REQ-026 ERROR and DONE are terminal until reset; all inputs ignored, counters frozen.
REQ-027 instr_cnt in the halt cycle includes a coincident commit.
REQ-028 Counters 32-bit unsigned; cycle_cnt cannot wrap (MAX_CYCLES < 2^32, parameter check at elaboration).

Reset
REQ-029 rst_n=0 immediately forces RUN; err=0, err_code=0, err_vec=0, done=0, cycle_cnt=0, instr_cnt=0, idle counter=0.
REQ-030 Reset mid-ERROR or mid-DONE returns to RUN; first count on first rising edge after rst_n=1.

Structure
REQ-031 Package sim_mon_pkg holds the state enum, the err_code enum, and the err_code width constant.
REQ-032 Sub-module sim_watchdog holds the idle counter and comparator, parameter WDOG_LIMIT, output timeout.
REQ-033 Target size: 150-300 lines of RTL total.

Verification
REQ-034 err_src=8'h04 pulse at RUN cycle 10 -> err=1, err_code=1, err_vec=8'h04 from cycle 11, sticky.
REQ-035 WDOG_LIMIT=5, commit never asserted -> err_code=2 after 5th idle cycle; commit at 4th idle cycle -> no error.
REQ-036 MAX_CYCLES=20, commit every cycle -> err_code=3, cycle_cnt=20, instr_cnt=20.
REQ-037 halt with err_src=8'h81 same cycle -> err_code=1, err_vec=8'h81, done=0.
REQ-038 halt after 7 commits -> done=1, instr_cnt=7; later err_src=8'hFF ignored, err=0.
REQ-039 rst_n low mid-count while in ERROR -> all outputs 0 asynchronously; counting resumes after release.
